// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle CPU control unit: instruction-sequencing FSM plus datapath control decode
module mc_control_unit #(
    parameter logic [5:0] OP_HALT = 6'b111111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [3:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       mRD,
    output logic       mWR
);

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_WB_AL  = 4'd3,
        S_EXE_BR = 4'd4,
        S_EXE_LS = 4'd5,
        S_MEM    = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    state_t cur, nxt;

    logic is_add, is_sub, is_addi, is_or, is_and, is_ori, is_sll, is_slt;
    logic is_sw, is_lw, is_beq, is_j, is_jr, is_jal, is_halt;
    logic is_rtype, is_arith, is_undef;

    assign is_add   = (opcode == OP_ADD);
    assign is_sub   = (opcode == OP_SUB);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_or    = (opcode == OP_OR);
    assign is_and   = (opcode == OP_AND);
    assign is_ori   = (opcode == OP_ORI);
    assign is_sll   = (opcode == OP_SLL);
    assign is_slt   = (opcode == OP_SLT);
    assign is_sw    = (opcode == OP_SW);
    assign is_lw    = (opcode == OP_LW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_jr    = (opcode == OP_JR);
    assign is_jal   = (opcode == OP_JAL);
    assign is_halt  = (opcode == OP_HALT);
    assign is_rtype = is_add | is_sub | is_or | is_and | is_sll | is_slt;
    assign is_arith = is_rtype | is_addi | is_ori;
    assign is_undef = ~(is_arith | is_sw | is_lw | is_beq | is_j | is_jr | is_jal | is_halt);

    assign state = cur;

    // State register; reset always returns to instruction fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_IF;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state sequencing per instruction class
    always_comb begin
        nxt = cur;
        case (cur)
            S_IF:     nxt = S_ID;
            S_ID: begin
                if (is_halt)              nxt = S_HALT;
                else if (is_beq)          nxt = S_EXE_BR;
                else if (is_lw || is_sw)  nxt = S_EXE_LS;
                else if (is_arith)        nxt = S_EXE_AL;
                else                      nxt = S_IF;
            end
            S_EXE_AL: nxt = S_WB_AL;
            S_WB_AL:  nxt = S_IF;
            S_EXE_BR: nxt = S_IF;
            S_EXE_LS: nxt = S_MEM;
            S_MEM:    nxt = is_lw ? S_WB_LD : S_IF;
            S_WB_LD:  nxt = S_IF;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_IF;
        endcase
    end

    // Datapath controls: ALU/extend selects from opcode, strobes from state, all strobes gated by reset
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        ALUSrcA   = is_sll;
        ALUSrcB   = is_addi | is_ori | is_lw | is_sw;
        ExtSel    = ~is_ori;
        ALUOp     = 3'b000;
        if (is_sub || is_beq)      ALUOp = 3'b001;
        else if (is_sll)           ALUOp = 3'b010;
        else if (is_or || is_ori)  ALUOp = 3'b011;
        else if (is_and)           ALUOp = 3'b100;
        else if (is_slt)           ALUOp = 3'b110;

        PCSrc = 2'b00;
        if (is_j || is_jal)                  PCSrc = 2'b11;
        else if (is_jr)                      PCSrc = 2'b10;
        else if ((cur == S_EXE_BR) && zero)  PCSrc = 2'b01;

        case (cur)
            S_IF: IRWre = 1'b1;
            S_ID: begin
                PCWre = is_j | is_jr | is_jal | is_undef;
                if (is_jal) begin
                    RegWre    = 1'b1;
                    RegDst    = 2'b00;
                    WrRegDSrc = 1'b0;
                end
            end
            S_EXE_BR: PCWre = 1'b1;
            S_MEM: begin
                mRD   = is_lw;
                mWR   = is_sw;
                PCWre = is_sw;
            end
            S_WB_AL: begin
                PCWre     = 1'b1;
                RegWre    = 1'b1;
                WrRegDSrc = 1'b1;
                RegDst    = is_rtype ? 2'b10 : 2'b01;
            end
            S_WB_LD: begin
                PCWre     = 1'b1;
                RegWre    = 1'b1;
                RegDst    = 2'b01;
                WrRegDSrc = 1'b1;
                DBDataSrc = 1'b1;
            end
            default: ;
        endcase

        if (rst) begin
            PCWre  = 1'b0;
            IRWre  = 1'b0;
            RegWre = 1'b0;
            mRD    = 1'b0;
            mWR    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - self-checking bench for mc_control_unit against an instruction-level model
module tb_mc_control_unit;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010, ORR = 6'b010000;
    localparam logic [5:0] ANDD = 6'b010001, ORI = 6'b010010, SLL = 6'b011000, SLT = 6'b100110;
    localparam logic [5:0] SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100, JMP = 6'b111000;
    localparam logic [5:0] JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111, UNDEF = 6'b000011;

    // instruction classes of the model
    localparam int C_JUMP = 0, C_ARITH = 1, C_BEQ = 2, C_LW = 3, C_SW = 4, C_HALT = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic [3:0] state;
    logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp;

    mc_control_unit #(.OP_HALT(HALT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .state(state),
        .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ExtSel(ExtSel), .RegWre(RegWre), .RegDst(RegDst),
        .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // expected values published by the stimulus, checked on every falling edge
    logic       chk_en = 1'b0;
    logic       exp_full;
    logic [3:0] exp_state;
    logic       exp_pcwre, exp_irwre, exp_regwre, exp_mrd, exp_mwr;
    logic [1:0] exp_pcsrc, exp_regdst;
    logic       exp_srca, exp_srcb, exp_ext, exp_wrsrc, exp_dbsrc;
    logic [2:0] exp_aluop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int cls(input logic [5:0] op);
        case (op)
            ADD, SUB, ADDI, ORR, ANDD, ORI, SLL, SLT: return C_ARITH;
            BEQ:  return C_BEQ;
            LW:   return C_LW;
            SW:   return C_SW;
            HALT: return C_HALT;
            default: return C_JUMP;
        endcase
    endfunction

    // state visited at step k of an instruction
    function automatic logic [3:0] path_state(input logic [5:0] op, input int k);
        logic [3:0] p [5];
        case (cls(op))
            C_ARITH: p = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
            C_BEQ:   p = '{4'd0, 4'd1, 4'd4, 4'd0, 4'd0};
            C_LW:    p = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7};
            C_SW:    p = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd0};
            default: p = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
        endcase
        return p[k];
    endfunction

    function automatic int path_len(input logic [5:0] op);
        case (cls(op))
            C_ARITH: return 4;
            C_BEQ:   return 3;
            C_LW:    return 5;
            C_SW:    return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op);
        case (op)
            SUB, BEQ: return 3'b001;
            SLL:      return 3'b010;
            ORR, ORI: return 3'b011;
            ANDD:     return 3'b100;
            SLT:      return 3'b110;
            default:  return 3'b000;
        endcase
    endfunction

    // opcode-only expectations (ALU/extend selects, jump PC select)
    task automatic set_decode(input logic [5:0] op);
        exp_srca  = (op == SLL);
        exp_srcb  = (op == ADDI) || (op == ORI) || (op == LW) || (op == SW);
        exp_ext   = (op != ORI);
        exp_aluop = alu_of(op);
        exp_pcsrc = (op == JMP || op == JAL) ? 2'b11 : (op == JR) ? 2'b10 : 2'b00;
    endtask

    // expectations for step k of instruction op, from the per-instruction rules
    task automatic set_exp(input logic [5:0] op, input logic z, input int k);
        int c, last;
        c    = cls(op);
        last = path_len(op) - 1;
        set_decode(op);
        exp_full   = 1'b1;
        exp_state  = path_state(op, k);
        exp_irwre  = (k == 0);
        exp_pcwre  = (c != C_HALT) && (k == last);
        exp_regwre = ((op == JAL) && (k == 1)) || ((c == C_ARITH || c == C_LW) && (k == last));
        exp_mrd    = (c == C_LW) && (k == 3);
        exp_mwr    = (c == C_SW) && (k == 3);
        if (c == C_BEQ && k == 2 && z) exp_pcsrc = 2'b01;
        exp_regdst = (op == JAL) ? 2'b00 :
                     (c == C_ARITH && op != ADDI && op != ORI) ? 2'b10 : 2'b01;
        exp_wrsrc  = (op != JAL);
        exp_dbsrc  = (c == C_LW);
    endtask

    task automatic set_quiet(input logic [3:0] st);
        exp_full   = 1'b0;
        exp_state  = st;
        exp_irwre  = 1'b0;
        exp_pcwre  = 1'b0;
        exp_regwre = 1'b0;
        exp_mrd    = 1'b0;
        exp_mwr    = 1'b0;
    endtask

    // the single compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", 32'(state), 32'(exp_state));
            chk("IRWre", 32'(IRWre), 32'(exp_irwre));
            chk("PCWre", 32'(PCWre), 32'(exp_pcwre));
            chk("RegWre", 32'(RegWre), 32'(exp_regwre));
            chk("mRD", 32'(mRD), 32'(exp_mrd));
            chk("mWR", 32'(mWR), 32'(exp_mwr));
            if (exp_full) begin
                chk("PCSrc", 32'(PCSrc), 32'(exp_pcsrc));
                chk("ALUSrcA", 32'(ALUSrcA), 32'(exp_srca));
                chk("ALUSrcB", 32'(ALUSrcB), 32'(exp_srcb));
                chk("ExtSel", 32'(ExtSel), 32'(exp_ext));
                chk("ALUOp", 32'(ALUOp), 32'(exp_aluop));
                if (exp_regwre) begin
                    chk("RegDst", 32'(RegDst), 32'(exp_regdst));
                    chk("WrRegDSrc", 32'(WrRegDSrc), 32'(exp_wrsrc));
                    chk("DBDataSrc", 32'(DBDataSrc), 32'(exp_dbsrc));
                end
            end
        end
    end

    logic [31:0] trace;
    int          pcw_count;

    // run one instruction; rst_at >= 0 asserts reset during that step instead of completing it
    task automatic run_instr(input logic [5:0] op, input logic z, input logic z_other, input int rst_at);
        trace     = 32'h0;
        pcw_count = 0;
        for (int k = 0; k < path_len(op); k++) begin
            opcode = op;
            zero   = (cls(op) == C_BEQ && k == 2) ? z : z_other;
            if (k == rst_at) begin
                rst = 1'b1;
                set_quiet(path_state(op, k));
            end else begin
                set_exp(op, z, k);
            end
            #1;
            trace = {trace[27:0], state};
            if (PCWre) pcw_count++;
            @(posedge clk);
            #1;
            if (k == rst_at) begin
                rst = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = ADD;
        zero   = 1'b0;
        set_quiet(4'd0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(ADD, 1'b0, 1'b1, -1);
        chk("add_trace", trace, 32'h0123);
        chk("add_pcwre_once", 32'(pcw_count), 32'd1);
        run_instr(SUB, 1'b0, 1'b1, -1);
        run_instr(ADDI, 1'b0, 1'b0, -1);
        run_instr(ORR, 1'b0, 1'b1, -1);
        run_instr(ANDD, 1'b0, 1'b0, -1);
        run_instr(ORI, 1'b0, 1'b1, -1);
        run_instr(SLL, 1'b0, 1'b0, -1);
        run_instr(SLT, 1'b0, 1'b1, -1);
        run_instr(LW, 1'b0, 1'b1, -1);
        chk("lw_trace", trace, 32'h01567);
        run_instr(SW, 1'b0, 1'b1, -1);
        chk("sw_trace", trace, 32'h0156);
        run_instr(BEQ, 1'b1, 1'b0, -1);
        chk("beq_trace", trace, 32'h014);
        chk("beq_pcwre_once", 32'(pcw_count), 32'd1);
        run_instr(BEQ, 1'b0, 1'b1, -1);
        run_instr(JMP, 1'b0, 1'b1, -1);
        run_instr(JR, 1'b0, 1'b1, -1);
        run_instr(JAL, 1'b0, 1'b1, -1);
        chk("jal_trace", trace, 32'h01);
        run_instr(UNDEF, 1'b0, 1'b1, -1);
        chk("undef_pcwre_once", 32'(pcw_count), 32'd1);

        // reset while a store is in its memory cycle
        run_instr(SW, 1'b0, 1'b0, 3);
        chk("sw_rst_trace", trace, 32'h0156);
        run_instr(ADD, 1'b0, 1'b1, -1);

        // halt holds for ten cycles with no writes, then a reset pulse restarts fetch
        run_instr(HALT, 1'b0, 1'b0, -1);
        for (int i = 0; i < 10; i++) begin
            opcode = HALT;
            zero   = i[0];
            set_quiet(4'd8);
            exp_full = 1'b1;
            set_decode(HALT);
            @(posedge clk);
            #1;
        end
        chk("halt_held", 32'(state), 32'd8);
        rst = 1'b1;
        set_quiet(4'd8);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_state", 32'(state), 32'd0);
        run_instr(JAL, 1'b0, 1'b1, -1);
        run_instr(LW, 1'b0, 1'b0, -1);

        chk_en = 1'b0;
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter OP_HALT, default 6'b111111, opcode that stops instruction sequencing.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  input  6  IR[31:26] of the current instruction.
REQ-005 SHALL have port zero  input  1  ALU zero flag for the current cycle.
REQ-006 SHALL have port state  output  4  current FSM state code.
REQ-007 SHALL have port PCWre  output  1  PC write enable.
REQ-008 SHALL have port IRWre  output  1  IR write enable.
REQ-009 SHALL have port PCSrc  output  2  next-PC select: 00 PC+4, 01 branch, 10 rs (jr), 11 jump target.
REQ-010 SHALL have port ALUSrcA  output  1  1 selects zero-extended sa, 0 selects rs.
REQ-011 SHALL have port ALUSrcB  output  1  1 selects extended immediate, 0 selects rt.
REQ-012 SHALL have port ALUOp  output  3  000 add, 001 sub, 010 B<<A, 011 or, 100 and, 110 signed less-than.
REQ-013 SHALL have port ExtSel  output  1  1 sign-extend, 0 zero-extend.
REQ-014 SHALL have port RegWre  output  1  register-file write enable.
REQ-015 SHALL have port RegDst  output  2  write address: 00 $31, 01 rt, 10 rd.
REQ-016 SHALL have port WrRegDSrc  output  1  write data: 0 PC+4, 1 data bus.
REQ-017 SHALL have port DBDataSrc  output  1  data bus: 0 ALU-result register, 1 memory-data register.
REQ-018 SHALL have ports mRD and mWR  output  1 each  data-memory read and write strobes.

Function
REQ-019 SHALL decode: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt = OP_HALT.
REQ-020 SHALL use state codes IF 0, ID 1, EXE_AL 2, WB_AL 3, EXE_BR 4, EXE_LS 5, MEM 6, WB_LD 7, HALT 8.
REQ-021 SHALL transition IF->ID unconditionally.
REQ-022 SHALL transition from ID: j/jr/jal->IF; beq->EXE_BR; lw/sw->EXE_LS; halt->HALT; arithmetic/logic->EXE_AL; undefined opcode->IF.
REQ-023 SHALL transition EXE_AL->WB_AL->IF, EXE_BR->IF, EXE_LS->MEM, MEM->IF for sw, MEM->WB_LD->IF for lw.
REQ-024 SHALL hold HALT with all write enables low until rst.
REQ-025 SHALL drive outputs combinationally from state and opcode; inter-stage data registers are clocked every cycle and need no enable.
REQ-026 SHALL assert IRWre only in IF.
REQ-027 SHALL assert PCWre exactly once per instruction, in its final cycle: ID (j, jr, jal, undefined), WB_AL, EXE_BR, MEM (sw), WB_LD.
REQ-028 SHALL set PCSrc 11 for j/jal, 10 for jr, 01 in EXE_BR when zero=1, and 00 otherwise.
REQ-029 SHALL assert RegWre only in ID for jal (RegDst 00, WrRegDSrc 0), in WB_AL (RegDst 10 for R-type, 01 for addi/ori; WrRegDSrc 1), and in WB_LD (RegDst 01, WrRegDSrc 1, DBDataSrc 1).
REQ-030 SHALL assert mRD only in MEM for lw and mWR only in MEM for sw; the two are never high together.
REQ-031 SHALL set ALUSrcB 1 for addi, ori, lw, sw; ALUSrcA 1 only for sll; ExtSel 0 only for ori.
REQ-032 SHALL set ALUOp: add/addi/lw/sw 000, sub/beq 001, sll 010, or/ori 011, and 100, slt 110.
REQ-033 SHALL sample zero only in EXE_BR; zero in any other state has no effect.

Reset
REQ-034 SHALL, with rst high at a posedge, set state to IF regardless of current state, including HALT and mid-instruction states such as MEM.
REQ-035 SHALL force PCWre, IRWre, RegWre, mRD and mWR to 0 while rst is high.
REQ-036 SHALL perform the first IRWre in the cycle after rst deasserts.

Verification
REQ-037 SHALL cover: add -> states 0,1,2,3,0; RegWre=1, RegDst=10 only in state 3; PCWre once.
REQ-038 SHALL cover: lw -> states 0,1,5,6,7,0; mRD=1 in state 6; RegWre=1, DBDataSrc=1 in state 7; sw -> 0,1,5,6,0 with mWR=1 in state 6.
REQ-039 SHALL cover: beq with zero=1 -> PCSrc=01 in state 4; with zero=0 -> PCSrc=00; both cases PCWre=1.
REQ-040 SHALL cover: jal -> states 0,1,0; in ID RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11.
REQ-041 SHALL cover: halt -> state 8 holds 10 cycles with PCWre=0; rst pulse -> state 0; rst asserted in state 6 (sw) -> mWR=0 and state 0 next cycle.
